regfile_mp: RTL

- Parametrised multi-port register file; successor to the single-write/dual-read register file.
- Adds configurable read/write port counts, byte-enabled writes and registered reads with write-to-read bypass.
- Adds an optional hardwired zero register, synchronous reset and a write-conflict flag.
- Sits in the datapath between decode (addresses) and execute/writeback stages.

---
 rtl/regfile_pkg.sv | 30 +++
 rtl/regfile_wr_merge.sv | 46 ++++
 rtl/regfile_mp.sv | 94 +++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared widths and the byte-merge helper used by every path that
// produces a post-write register word.
package regfile_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_REG_COUNT  = 32;

    // Widest word merge_bytes handles; callers widen and truncate around it.
    localparam int MAX_DATA_WIDTH = 256;
    localparam int MAX_BE_WIDTH   = MAX_DATA_WIDTH / 8;

    function automatic int BE_W(input int data_width);
        return data_width / 8;
    endfunction

    function automatic logic [MAX_DATA_WIDTH-1:0] merge_bytes(
        input logic [MAX_DATA_WIDTH-1:0] old_word,
        input logic [MAX_DATA_WIDTH-1:0] new_word,
        input logic [MAX_BE_WIDTH-1:0]   be
    );
        logic [MAX_DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int b = 0; b < MAX_BE_WIDTH; b++) begin
            if (be[b]) merged[8*b +: 8] = new_word[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/regfile_wr_merge.sv
// Post-write value of one target address given every write port this cycle.
// Shared by storage update and read bypass so the two can never disagree.
module regfile_wr_merge
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int REG_COUNT  = DEF_REG_COUNT,
    parameter int NUM_WR     = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic [ADDR_WIDTH-1:0]                target,
    input  logic [DATA_WIDTH-1:0]                cur_word,
    input  logic [NUM_WR-1:0]                    wr_en,
    input  logic [NUM_WR*ADDR_WIDTH-1:0]         wr_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0]         wr_data,
    input  logic [NUM_WR*BE_W(DATA_WIDTH)-1:0]   wr_be,
    output logic [DATA_WIDTH-1:0]                next_word,
    output logic                                 overlap
);

    localparam int BW = BE_W(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] acc;
    logic [BW-1:0]         seen;

    // Ports are applied in ascending order, so the highest port wins a shared byte.
    always_comb begin
        acc     = cur_word;
        seen    = '0;
        overlap = 1'b0;
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en[p] && (wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == target)
                && (int'(target) < REG_COUNT)) begin
                overlap = overlap | (|(seen & wr_be[p*BW +: BW]));
                seen    = seen | wr_be[p*BW +: BW];
                acc     = DATA_WIDTH'(merge_bytes(MAX_DATA_WIDTH'(acc),
                                                  MAX_DATA_WIDTH'(wr_data[p*DATA_WIDTH +: DATA_WIDTH]),
                                                  MAX_BE_WIDTH'(wr_be[p*BW +: BW])));
            end
        end
        next_word = acc;
        if ((ZERO_REG != 0) && (target == '0)) next_word = '0;
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: byte-enabled writes, registered reads with
// write-first bypass, optional hardwired zero register and conflict flag.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int REG_COUNT  = DEF_REG_COUNT,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_WR-1:0]                    wr_en,
    input  logic [NUM_WR*ADDR_WIDTH-1:0]         wr_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0]         wr_data,
    input  logic [NUM_WR*BE_W(DATA_WIDTH)-1:0]   wr_be,
    input  logic [NUM_RD-1:0]                    rd_en,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]         rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0]         rd_data,
    output logic [NUM_RD-1:0]                    rd_valid,
    output logic [NUM_WR-1:0]                    wr_ack,
    output logic                                 wr_conflict
);

    logic [DATA_WIDTH-1:0]        regs [REG_COUNT];
    logic [NUM_WR-1:0]            wr_ok;
    logic [NUM_WR-1:0]            wr_overlap;
    logic [NUM_WR*DATA_WIDTH-1:0] wr_word;
    logic [NUM_RD*DATA_WIDTH-1:0] rd_word;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return int'(a) < REG_COUNT;
    endfunction

    for (genvar p = 0; p < NUM_WR; p++) begin : g_wr
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] cur;
        assign addr     = wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
        assign wr_ok[p] = wr_en[p] && in_range(addr);
        assign cur      = in_range(addr) ? regs[addr] : '0;

        regfile_wr_merge #(
            .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .REG_COUNT(REG_COUNT),
            .NUM_WR(NUM_WR), .ZERO_REG(ZERO_REG)
        ) u_merge (
            .target(addr), .cur_word(cur),
            .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
            .next_word(wr_word[p*DATA_WIDTH +: DATA_WIDTH]),
            .overlap(wr_overlap[p])
        );
    end

    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] cur;
        assign addr = rd_addr[r*ADDR_WIDTH +: ADDR_WIDTH];
        assign cur  = in_range(addr) ? regs[addr] : '0;

        regfile_wr_merge #(
            .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .REG_COUNT(REG_COUNT),
            .NUM_WR(NUM_WR), .ZERO_REG(ZERO_REG)
        ) u_merge (
            .target(addr), .cur_word(cur),
            .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
            .next_word(rd_word[r*DATA_WIDTH +: DATA_WIDTH]),
            .overlap()
        );
    end

    // Ports hitting the same address compute the same merged word, so both stores agree.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
            rd_data     <= '0;
            rd_valid    <= '0;
            wr_ack      <= '0;
            wr_conflict <= 1'b0;
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_ok[p])
                    regs[wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH]] <= wr_word[p*DATA_WIDTH +: DATA_WIDTH];
            end
            for (int r = 0; r < NUM_RD; r++) begin
                if (rd_en[r]) rd_data[r*DATA_WIDTH +: DATA_WIDTH] <= rd_word[r*DATA_WIDTH +: DATA_WIDTH];
            end
            rd_valid    <= rd_en;
            wr_ack      <= wr_ok;
            wr_conflict <= |wr_overlap;
        end
    end

endmodule
